// File: rtl/adc_decim_capture_ctrl.sv
// rtl/adc_decim_capture_ctrl.sv - triggered ADC decimator that captures one frame onto a stream master
// Latches ratio/length on start, waits for trig, emits every R-th sample until L samples are loaded.
module adc_decim_capture_ctrl #(
   parameter int DATA_WIDTH = 12,
   parameter int MAX_RATIO  = 256,
   parameter int MAX_LEN    = 1024,
   localparam int RW        = $clog2(MAX_RATIO),
   localparam int LW        = $clog2(MAX_LEN)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [RW-1:0]         cfg_decim,
   input  logic [LW-1:0]         cfg_len,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  trig,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      FLUSH   = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [RW-1:0]         ratio_q, ratio_d;
   logic [LW-1:0]         len_q, len_d;
   logic [RW-1:0]         dcnt_q, dcnt_d;
   logic [LW-1:0]         scnt_q, scnt_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                  tvalid_q, tvalid_d;
   logic                  tlast_q, tlast_d;
   logic                  done_q, done_d;
   logic                  ovf_q, ovf_d;

   logic accept;
   logic point;
   logic out_free;
   logic last_sample;

   assign accept      = tvalid_q & m_axis_tready;
   assign point       = (state_q == CAPTURE) && (dcnt_q == ratio_q);
   assign out_free    = ~tvalid_q | accept;
   assign last_sample = (scnt_q == len_q);

   always_comb begin
      state_d  = state_q;
      ratio_d  = ratio_q;
      len_d    = len_q;
      dcnt_d   = dcnt_q;
      scnt_d   = scnt_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q;

      if (accept) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               ratio_d = cfg_decim;
               len_d   = cfg_len;
               ovf_d   = 1'b0;
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (trig) begin
               dcnt_d  = '0;
               scnt_d  = '0;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            dcnt_d = (dcnt_q == ratio_q) ? '0 : dcnt_q + 1'b1;
            // A point that finds the output register still held is lost, not queued.
            if (point) begin
               if (out_free) begin
                  tdata_d  = data_in;
                  tvalid_d = 1'b1;
                  tlast_d  = last_sample;
                  if (last_sample) begin
                     scnt_d  = '0;
                     state_d = FLUSH;
                  end else begin
                     scnt_d = scnt_q + 1'b1;
                  end
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end
         FLUSH: begin
            if (accept && tlast_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort keeps the latched config and the sticky overflow; only the frame is dropped.
      if (abort) begin
         state_d  = IDLE;
         ratio_d  = ratio_q;
         len_d    = len_q;
         dcnt_d   = '0;
         scnt_d   = '0;
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
         done_d   = 1'b0;
         ovf_d    = ovf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ratio_q  <= '0;
         len_q    <= '0;
         dcnt_q   <= '0;
         scnt_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ratio_q  <= ratio_d;
         len_q    <= len_d;
         dcnt_q   <= dcnt_d;
         scnt_q   <= scnt_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign overflow      = ovf_q;

endmodule
